// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I control sequencer with bus timeout and retire counter.
// Define CTRL_ILLEGAL_TRAP_EN to halt on unknown opcodes; otherwise they retire as NOPs.
module control_fsm #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      instr,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           ALUo,
  output logic                 ALUs,
  output logic                 br,
  output logic                 mr,
  output logic                 mw,
  output logic                 rw,
  output logic                 mtr,
  output logic                 bus_err,
  output logic                 illegal,
  output logic [RET_CNT_W-1:0] ret_cnt
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;
  logic [2:0]           state_q, state_d;
  logic [6:0]           op_q;
  logic [TW-1:0]        to_q, to_d;
  logic [RET_CNT_W-1:0] ret_q;
  logic                 bus_err_q, ill_q;
  logic                 is_r, is_i, is_ld, is_st, is_br, known, busy, tmo;
  logic                 unused_ok;
  assign unused_ok = ^instr[XLEN-1:7];
  assign is_r  = op_q == 7'b0110011;
  assign is_i  = op_q == 7'b0010011;
  assign is_ld = op_q == 7'b0000011;
  assign is_st = op_q == 7'b0100011;
  assign is_br = op_q == 7'b1100011;
  assign known = is_r | is_i | is_ld | is_st | is_br;
  assign busy  = state_q == FETCH || state_q == MEM;
  // A response arriving on the last allowed cycle still counts, so tmo needs mem_ready low
  assign tmo   = busy && !mem_ready && to_q == TW'(MEM_TIMEOUT - 1);
  assign to_d  = busy && !mem_ready && !tmo ? to_q + TW'(1) : '0;
  assign mem_req = busy;
  assign ir_we   = state_q == FETCH && mem_ready;
  assign ALUo    = state_q != EXEC ? 2'b00 : is_br ? 2'b01 : (is_r || is_i) ? 2'b10 : 2'b00;
  assign ALUs    = (state_q == EXEC && (is_i || is_ld || is_st)) || state_q == MEM;
  assign br      = state_q == EXEC && is_br;
  assign mr      = state_q == MEM && is_ld;
  assign mw      = state_q == MEM && is_st;
  assign rw      = state_q == WB;
  assign mtr     = state_q == WB && is_ld;
  assign pc_we   = br || (mw && mem_ready) || rw || (state_q == DECODE && !known && !TRAP);
  assign bus_err = bus_err_q;
  assign illegal = ill_q;
  assign ret_cnt = ret_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = tmo ? HALT : mem_ready ? DECODE : FETCH;
      DECODE:  state_d = known ? EXEC : TRAP ? HALT : FETCH;
      EXEC:    state_d = is_br ? FETCH : (is_ld || is_st) ? MEM : WB;
      MEM:     state_d = tmo ? HALT : !mem_ready ? MEM : is_ld ? WB : FETCH;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      to_q      <= '0;
      ret_q     <= '0;
      bus_err_q <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= ir_we ? instr[6:0] : op_q;
      to_q      <= to_d;
      ret_q     <= ret_q + RET_CNT_W'(pc_we);
      bus_err_q <= bus_err_q | tmo;
      ill_q     <= ill_q | (TRAP && state_q == DECODE && !known);
    end
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: randomized instruction stream checked cycle by cycle against a per-instruction phase script.
module tb_control_fsm;
  logic        clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_req, ir_we, pc_we, ALUs, br, mr, mw, rw, mtr, bus_err, illegal;
  logic [1:0]  ALUo, ret_cnt;
  int          checks = 0, passed = 0;
  logic        exp_bus = 1'b0, exp_ill = 1'b0;
  logic [1:0]  exp_ret = '0;

  control_fsm #(.XLEN(32), .MEM_TIMEOUT(16), .RET_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we), .ALUo(ALUo), .ALUs(ALUs),
    .br(br), .mr(mr), .mw(mw), .rw(rw), .mtr(mtr),
    .bus_err(bus_err), .illegal(illegal), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [10:0] cv(input logic req, input logic irw, input logic pcw,
                                     input logic [1:0] aluo, input logic alus, input logic b,
                                     input logic r, input logic w, input logic rwr, input logic m);
    return {req, irw, pcw, aluo, alus, b, r, w, rwr, m};
  endfunction

  task automatic sample(input string tag, input logic [10:0] c);
    chk(tag, {17'b0, bus_err, illegal, ret_cnt, mem_req, ir_we, pc_we, ALUo, ALUs, br, mr, mw, rw, mtr},
             {17'b0, exp_bus, exp_ill, exp_ret, c});
    if (c[8]) exp_ret++;
  endtask

  task automatic step(input logic rdy, input logic [31:0] iw, input logic [10:0] c, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    instr = iw;
    #1 sample(tag, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    exp_bus = 1'b0;
    exp_ill = 1'b0;
    exp_ret = '0;
    sample("reset", 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 sample("idle", 11'd0);
  endtask

  task automatic halt_seq();
    repeat (3) step(1'($urandom), $urandom, 11'd0, "halt");
    do_reset();
  endtask

  task automatic run(input logic [31:0] iw, input int fw, input int mwt);
    logic r, i, ld, st, b;
    r  = iw[6:0] == 7'h33;
    i  = iw[6:0] == 7'h13;
    ld = iw[6:0] == 7'h03;
    st = iw[6:0] == 7'h23;
    b  = iw[6:0] == 7'h63;
    for (int k = 0; k < fw && k < 16; k++)
      step(1'b0, $urandom, cv(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fetch_wait");
    if (fw >= 16) begin
      exp_bus = 1'b1;
      halt_seq();
      return;
    end
    step(1'b1, iw, cv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "fetch");
    if (!(r | i | ld | st | b)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      step(1'($urandom), $urandom, 11'd0, "decode_ill");
      exp_ill = 1'b1;
      halt_seq();
`else
      step(1'($urandom), $urandom, cv(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "decode_nop");
`endif
      return;
    end
    step(1'($urandom), $urandom, 11'd0, "decode");
    step(1'($urandom), $urandom, cv(1'b0, 1'b0, b, b ? 2'b01 : (r | i) ? 2'b10 : 2'b00,
                                    i | ld | st, b, 1'b0, 1'b0, 1'b0, 1'b0), "exec");
    if (b) return;
    if (ld | st) begin
      for (int k = 0; k < mwt && k < 16; k++)
        step(1'b0, $urandom, cv(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, ld, st, 1'b0, 1'b0), "mem_wait");
      if (mwt >= 16) begin
        exp_bus = 1'b1;
        halt_seq();
        return;
      end
      step(1'b1, $urandom, cv(1'b1, 1'b0, st, 2'b00, 1'b1, 1'b0, ld, st, 1'b0, 1'b0), "mem");
      if (st) return;
    end
    step(1'($urandom), $urandom, cv(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ld), "wb");
  endtask

  function automatic logic [31:0] mk(input int cls);
    logic [6:0]  ops [0:8];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h37, 7'h6F, 7'h00};
    w = $urandom;
    w[6:0] = ops[cls];
    return w;
  endfunction

  initial begin
    do_reset();
    run(32'h003100B3, 0, 0);
    run(32'h00012083, 0, 2);
    run(32'h00112023, 0, 0);
    run(32'hFE000EE3, 0, 0);
    run(32'h0000007F, 0, 0);
    for (int n = 0; n < 60; n++)
      run(mk(($urandom_range(0, 9) == 0) ? $urandom_range(5, 8) : $urandom_range(0, 4)),
          $urandom_range(0, 3), $urandom_range(0, 3));
    run(32'h00012083, 15, 15);
    run(32'h00112023, 15, 15);
    run(32'h003100B3, 16, 0);
    run(32'h00012083, 0, 16);
    run(32'h00112023, 1, 16);
    run(32'h003100B3, 0, 0);
    step(1'b1, 32'h00012083, cv(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "abort_fetch");
    step(1'b0, $urandom, 11'd0, "abort_decode");
    step(1'b0, $urandom, cv(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "abort_exec");
    step(1'b0, $urandom, cv(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "abort_mem");
    do_reset();
    for (int n = 0; n < 5; n++) run(mk(n), 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
